vga_fetch_sched: RTL

//  Schedules framebuffer reads for the VGA output path, in the pixel_clk domain.
//  Per frame, issues a sequence of burst requests (addr,len) to the Wishbone read

---
 rtl/vga_fetch_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_fetch_sched.sv
// Framebuffer fetch scheduler for the VGA pixel FIFO: one outstanding burst at a time,
// resynchronised on every frame_start, with sticky underflow / late-frame flags.
module vga_fetch_sched #(
  parameter int              HDISP      = 800,
  parameter int              VDISP      = 480,
  parameter int              FIFO_DEPTH = 256,
  parameter int              BURST_LEN  = 16,
  parameter int              AW         = 32,
  parameter logic [AW-1:0]   BASE_ADDR  = '0
) (
  input  logic                             pixel_clk,
  input  logic                             pixel_rst,
  input  logic                             enable,
  input  logic                             frame_start,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  input  logic                             pix_rd,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [AW-1:0]                    req_addr,
  output logic [$clog2(BURST_LEN+1)-1:0]   req_len,
  input  logic                             burst_done,
  output logic                             fifo_flush,
  output logic                             frame_busy,
  output logic                             underflow,
  output logic                             late_frame,
  input  logic                             err_clr
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int IW    = $clog2(((TOTAL > BURST_LEN) ? TOTAL : BURST_LEN) + 1);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int RLW   = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_FLUSH,
    S_CHECK,
    S_REQ,
    S_WAIT
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  word_idx, word_idx_next, remaining;
  logic [RLW-1:0] len_calc, req_len_next;
  logic [AW-1:0]  addr_calc, req_addr_next;
  logic           req_valid_next, fifo_flush_next, frame_busy_next;
  logic           underflow_next, late_frame_next;
  logic           pending, pending_next;
  logic           resync_req, space_ok;

  assign remaining  = IW'(TOTAL) - word_idx;
  // The final burst of a frame is clipped so no request runs past the last pixel.
  assign len_calc   = (remaining > IW'(BURST_LEN)) ? RLW'(BURST_LEN) : RLW'(remaining);
  assign addr_calc  = BASE_ADDR + AW'({word_idx, 2'b00});
  assign space_ok   = ({1'b0, fifo_level} + (LW+1)'(len_calc)) <= (LW+1)'(FIFO_DEPTH);
  assign resync_req = frame_start & frame_busy;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_next      = state;
    req_valid_next  = req_valid;
    req_addr_next   = req_addr;
    req_len_next    = req_len;
    fifo_flush_next = 1'b0;
    frame_busy_next = frame_busy;
    word_idx_next   = word_idx;
    pending_next    = pending | resync_req;

    underflow_next  = err_clr ? 1'b0 : underflow;
    if (pix_rd && (fifo_level == '0) && frame_busy) begin
      underflow_next = 1'b1;
    end
    late_frame_next = err_clr ? 1'b0 : late_frame;
    if (resync_req) begin
      late_frame_next = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_SYNC;
        end
      end
      S_SYNC: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (frame_start) begin
          state_next      = S_FLUSH;
          fifo_flush_next = 1'b1;
        end
      end
      S_FLUSH: begin
        state_next      = S_CHECK;
        word_idx_next   = '0;
        frame_busy_next = 1'b1;
        pending_next    = resync_req;
      end
      S_CHECK: begin
        if (!enable) begin
          state_next      = S_IDLE;
          frame_busy_next = 1'b0;
          pending_next    = 1'b0;
        end else if (pending_next) begin
          state_next      = S_FLUSH;
          fifo_flush_next = 1'b1;
        end else if (remaining == '0) begin
          state_next      = S_SYNC;
          frame_busy_next = 1'b0;
        end else if (space_ok) begin
          state_next     = S_REQ;
          req_valid_next = 1'b1;
          req_addr_next  = addr_calc;
          req_len_next   = len_calc;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          state_next     = S_WAIT;
          req_valid_next = 1'b0;
        end
      end
      S_WAIT: begin
        if (burst_done) begin
          word_idx_next = word_idx + IW'(req_len);
          if (pending_next) begin
            state_next      = S_FLUSH;
            fifo_flush_next = 1'b1;
          end else begin
            state_next = S_CHECK;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state      <= S_IDLE;
      req_valid  <= 1'b0;
      req_addr   <= BASE_ADDR;
      req_len    <= '0;
      fifo_flush <= 1'b0;
      frame_busy <= 1'b0;
      underflow  <= 1'b0;
      late_frame <= 1'b0;
      word_idx   <= '0;
      pending    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      req_valid  <= req_valid_next;
      req_addr   <= req_addr_next;
      req_len    <= req_len_next;
      fifo_flush <= fifo_flush_next;
      frame_busy <= frame_busy_next;
      underflow  <= underflow_next;
      late_frame <= late_frame_next;
      word_idx   <= word_idx_next;
      pending    <= pending_next;
    end
  end

  // A pending request must stay frozen until the read engine takes it.
  req_hold_a : assert property (@(posedge pixel_clk) disable iff (pixel_rst)
    req_valid && !req_ready |=> req_valid && $stable(req_addr) && $stable(req_len));

endmodule
